// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register: RV32I ALU-op decode, operand forwarding and select, valid/ready hold.
module id_ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            exm_wen,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            mwb_wen,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_wen,
    output logic            ex_illegal
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_ZERO = 2'd1;
    localparam logic [1:0] A_PC   = 2'd2;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [4:0]      r_rs1_addr;
    logic [4:0]      r_rs2_addr;
    logic [4:0]      r_rd_addr;
    logic [3:0]      r_alu_op;
    logic [1:0]      r_a_sel;
    logic            r_b_imm;
    logic            r_wen;
    logic            r_illegal;

    logic            w_capture;
    logic [3:0]      w_dec_op;
    logic [1:0]      w_dec_a_sel;
    logic            w_dec_b_imm;
    logic            w_dec_wen;
    logic            w_dec_illegal;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;

    // Shared funct3 table for OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_alu = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f3_alu = ALU_SLL;
            3'b010:  f3_alu = ALU_SLT;
            3'b011:  f3_alu = ALU_SLTU;
            3'b100:  f3_alu = ALU_XOR;
            3'b101:  f3_alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_alu = ALU_OR;
            default: f3_alu = ALU_AND;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] fwd(input logic [4:0] rs, input logic [XLEN-1:0] stored,
                                            input logic e_wen, input logic [4:0] e_rd,
                                            input logic [XLEN-1:0] e_data,
                                            input logic m_wen, input logic [4:0] m_rd,
                                            input logic [XLEN-1:0] m_data);
        if (e_wen && (e_rd == rs) && (rs != 5'd0))
            fwd = e_data;
        else if (m_wen && (m_rd == rs) && (rs != 5'd0))
            fwd = m_data;
        else
            fwd = stored;
    endfunction

    always_comb begin
        w_dec_op      = ALU_ADD;
        w_dec_a_sel   = A_RS1;
        w_dec_b_imm   = 1'b0;
        w_dec_wen     = 1'b0;
        w_dec_illegal = 1'b0;
        case (in_opcode)
            OPC_OP: begin
                w_dec_op  = f3_alu(in_funct3, in_funct7b5);
                w_dec_wen = 1'b1;
            end
            OPC_OPIMM: begin
                w_dec_op    = f3_alu(in_funct3, in_funct3 == 3'b101 && in_funct7b5);
                w_dec_b_imm = 1'b1;
                w_dec_wen   = 1'b1;
            end
            OPC_LUI: begin
                w_dec_a_sel = A_ZERO;
                w_dec_b_imm = 1'b1;
                w_dec_wen   = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec_a_sel = A_PC;
                w_dec_b_imm = 1'b1;
                w_dec_wen   = 1'b1;
            end
            OPC_LOAD: begin
                w_dec_b_imm = 1'b1;
                w_dec_wen   = 1'b1;
            end
            OPC_STORE: begin
                w_dec_b_imm = 1'b1;
            end
            OPC_BRANCH: begin
                case (in_funct3[2:1])
                    2'b00:   w_dec_op = ALU_SUB;
                    2'b10:   w_dec_op = ALU_SLT;
                    2'b11:   w_dec_op = ALU_SLTU;
                    default: w_dec_op = ALU_ADD;
                endcase
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    assign in_ready  = !r_valid || ex_ready;
    assign w_capture = in_valid && in_ready && !flush;

    assign w_rs1_fwd = fwd(r_rs1_addr, r_rs1_val, exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data);
    assign w_rs2_fwd = fwd(r_rs2_addr, r_rs2_val, exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1_val  <= '0;
            r_rs2_val  <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_alu_op   <= ALU_AND;
            r_a_sel    <= A_RS1;
            r_b_imm    <= 1'b0;
            r_wen      <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            if (flush)
                r_valid <= 1'b0;
            else if (w_capture)
                r_valid <= 1'b1;
            else if (r_valid && ex_ready)
                r_valid <= 1'b0;

            if (w_capture) begin
                r_pc       <= in_pc;
                r_imm      <= in_imm;
                r_rs1_val  <= in_rs1_data;
                r_rs2_val  <= in_rs2_data;
                r_rs1_addr <= in_rs1_addr;
                r_rs2_addr <= in_rs2_addr;
                r_rd_addr  <= in_rd_addr;
                r_alu_op   <= w_dec_op;
                r_a_sel    <= w_dec_a_sel;
                r_b_imm    <= w_dec_b_imm;
                r_wen      <= w_dec_wen && (in_rd_addr != 5'd0);
                r_illegal  <= w_dec_illegal;
            end else if (r_valid && !ex_ready) begin
                // Latch forwarded operands while stalled so they outlive the producer.
                r_rs1_val <= w_rs1_fwd;
                r_rs2_val <= w_rs2_fwd;
            end
        end
    end

    always_comb begin
        case (r_a_sel)
            A_ZERO:  alu_a = '0;
            A_PC:    alu_a = r_pc;
            default: alu_a = w_rs1_fwd;
        endcase
    end

    assign alu_b      = r_b_imm ? r_imm : w_rs2_fwd;
    assign alu_op     = r_alu_op;
    assign ex_rs2_val = w_rs2_fwd;
    assign ex_rd_addr = r_rd_addr;
    assign ex_wen     = r_wen;
    assign ex_illegal = r_illegal;
    assign ex_valid   = r_valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - randomized + directed bench for id_ex_operand_stage with behavioural model.
module tb_id_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        exm_wen, mwb_wen;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_data, mwb_data;
    logic        ex_valid, ex_ready;
    logic [31:0] alu_a, alu_b, ex_rs2_val;
    logic [3:0]  alu_op;
    logic [4:0]  ex_rd_addr;
    logic        ex_wen, ex_illegal;

    id_ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_rs2_val(ex_rs2_val),
        .ex_rd_addr(ex_rd_addr), .ex_wen(ex_wen), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the held instruction: raw fields plus stored operand values.
    logic        m_valid;
    logic [31:0] m_pc, m_imm, m_v1, m_v2;
    logic [6:0]  m_opc;
    logic [2:0]  m_f3;
    logic        m_f7;
    logic [4:0]  m_rs1, m_rs2, m_rd;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] a_kind;   // 0 rs1, 1 zero, 2 pc
        logic       b_imm;
        logic       wen;
        logic       ill;
    } dec_t;

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
        logic [3:0] tbl [8];
        tbl = '{4'd2, 4'd5, 4'd7, 4'd10, 4'd4, 4'd8, 4'd1, 4'd0};
        if (alt && f3 == 3'd0) return 4'd6;
        if (alt && f3 == 3'd5) return 4'd9;
        return tbl[f3];
    endfunction

    function automatic dec_t ref_dec(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        dec_t d;
        d = '{op: 4'd2, a_kind: 2'd0, b_imm: 1'b0, wen: 1'b0, ill: 1'b0};
        if (opc == 7'h33) begin d.op = ref_alu(f3, f7); d.wen = 1'b1; end
        else if (opc == 7'h13) begin d.op = ref_alu(f3, f7 && f3 == 3'd5); d.b_imm = 1'b1; d.wen = 1'b1; end
        else if (opc == 7'h37) begin d.a_kind = 2'd1; d.b_imm = 1'b1; d.wen = 1'b1; end
        else if (opc == 7'h17) begin d.a_kind = 2'd2; d.b_imm = 1'b1; d.wen = 1'b1; end
        else if (opc == 7'h03) begin d.b_imm = 1'b1; d.wen = 1'b1; end
        else if (opc == 7'h23) d.b_imm = 1'b1;
        else if (opc == 7'h63) begin
            if (f3 == 3'd0 || f3 == 3'd1) d.op = 4'd6;
            else if (f3 == 3'd4 || f3 == 3'd5) d.op = 4'd7;
            else if (f3 == 3'd6 || f3 == 3'd7) d.op = 4'd10;
        end else d.ill = 1'b1;
        return d;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] stored);
        if (rs == 5'd0) return stored;
        if (exm_wen && exm_rd == rs) return exm_data;
        if (mwb_wen && mwb_rd == rs) return mwb_data;
        return stored;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_imm = '0; m_v1 = '0; m_v2 = '0;
        m_opc = '0; m_f3 = '0; m_f7 = 1'b0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    endtask

    task automatic compare();
        dec_t d;
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("in_ready", 32'(in_ready), 32'(!m_valid || ex_ready));
        if (m_valid) begin
            d = ref_dec(m_opc, m_f3, m_f7);
            chk("alu_op", 32'(alu_op), 32'(d.op));
            chk("alu_a", alu_a, d.a_kind == 2'd1 ? 32'd0 : d.a_kind == 2'd2 ? m_pc : ref_fwd(m_rs1, m_v1));
            chk("alu_b", alu_b, d.b_imm ? m_imm : ref_fwd(m_rs2, m_v2));
            chk("ex_rs2_val", ex_rs2_val, ref_fwd(m_rs2, m_v2));
            chk("ex_rd_addr", 32'(ex_rd_addr), 32'(m_rd));
            chk("ex_wen", 32'(ex_wen), 32'(d.wen && m_rd != 5'd0));
            chk("ex_illegal", 32'(ex_illegal), 32'(d.ill));
        end
    endtask

    task automatic model_advance();
        logic cap, nv;
        cap = in_valid && (!m_valid || ex_ready) && !flush;
        nv  = flush ? 1'b0 : cap ? 1'b1 : (m_valid && ex_ready) ? 1'b0 : m_valid;
        if (cap) begin
            m_pc = in_pc; m_imm = in_imm; m_v1 = in_rs1_data; m_v2 = in_rs2_data;
            m_opc = in_opcode; m_f3 = in_funct3; m_f7 = in_funct7b5;
            m_rs1 = in_rs1_addr; m_rs2 = in_rs2_addr; m_rd = in_rd_addr;
        end else if (m_valid && !ex_ready) begin
            m_v1 = ref_fwd(m_rs1, m_v1);
            m_v2 = ref_fwd(m_rs2, m_v2);
        end
        m_valid = nv;
    endtask

    // Inputs are set just after a negedge; check, predict the posedge, move on.
    task automatic step();
        #1;
        compare();
        model_advance();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        exm_wen = 1'b0; exm_rd = '0; exm_data = '0;
        mwb_wen = 1'b0; mwb_rd = '0; mwb_data = '0;
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] v1, input logic [31:0] v2,
                             input logic [31:0] imm, input logic [31:0] pc);
        in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7b5 = f7;
        in_rs1_addr = rs1; in_rs2_addr = rs2; in_rd_addr = rd;
        in_rs1_data = v1; in_rs2_data = v2; in_imm = imm; in_pc = pc;
    endtask

    logic [6:0] opcs [7];

    initial begin
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63};
        rst_n = 1'b0;
        idle();
        set_instr(7'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        in_valid = 1'b0;
        model_reset();

        @(negedge clk);
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        #1;
        chk("idle_ex_valid", 32'(ex_valid), 32'd0);
        chk("idle_alu_b", alu_b, 32'd0);

        // R-type SUB
        set_instr(7'h33, 3'd0, 1'b1, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd0, 32'd0);
        step();
        idle(); #1;
        chk("sub_valid", 32'(ex_valid), 32'd1);
        chk("sub_op", 32'(alu_op), 32'h6);
        chk("sub_a", alu_a, 32'd10);
        chk("sub_b", alu_b, 32'd3);
        chk("sub_wen", 32'(ex_wen), 32'd1);

        // OP-IMM funct7b5 must not turn ADDI into SUB
        set_instr(7'h13, 3'd0, 1'b1, 5'd1, 5'd2, 5'd5, 32'd10, 32'd3, 32'd5, 32'd0);
        step();
        idle(); #1;
        chk("addi_op", 32'(alu_op), 32'h2);
        chk("addi_b", alu_b, 32'd5);

        // Forward priority: EX/MEM over MEM/WB
        set_instr(7'h33, 3'd0, 1'b0, 5'd7, 5'd0, 5'd1, 32'h1234, 32'd0, 32'd0, 32'd0);
        step();
        idle();
        exm_wen = 1'b1; exm_rd = 5'd7; exm_data = 32'hAAAA;
        mwb_wen = 1'b1; mwb_rd = 5'd7; mwb_data = 32'hBBBB;
        #1;
        chk("fwd_prio_a", alu_a, 32'hAAAA);
        step();

        // x0 never forwards
        set_instr(7'h33, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 32'd0);
        step();
        idle();
        exm_wen = 1'b1; exm_rd = 5'd0; exm_data = 32'hAAAA;
        #1;
        chk("fwd_x0_a", alu_a, 32'd0);
        step();

        // Stall refresh keeps a forwarded operand after the producer retires
        idle();
        set_instr(7'h33, 3'd0, 1'b0, 5'd3, 5'd4, 5'd6, 32'd1, 32'd2, 32'd0, 32'd0);
        step();
        idle();
        ex_ready = 1'b0;
        mwb_wen = 1'b1; mwb_rd = 5'd4; mwb_data = 32'h55;
        step();
        mwb_wen = 1'b0;
        set_instr(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 5'd9, 32'd7, 32'd8, 32'd0, 32'd0);
        #1;
        chk("stall_b", alu_b, 32'h55);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        step();
        #1;
        chk("stall_hold_b", alu_b, 32'h55);
        chk("stall_hold_rd", 32'(ex_rd_addr), 32'd6);
        ex_ready = 1'b1;
        step();
        idle(); #1;
        chk("stall_release_rd", 32'(ex_rd_addr), 32'd9);
        chk("stall_release_b", alu_b, 32'd8);

        // Flush overrides same-cycle capture
        set_instr(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 32'd0, 32'd0);
        flush = 1'b1;
        step();
        idle(); #1;
        chk("flush_cap_valid", 32'(ex_valid), 32'd0);

        // Flush while stalled
        set_instr(7'h33, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 32'd0, 32'd0);
        step();
        idle();
        ex_ready = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; #1;
        chk("flush_stall_valid", 32'(ex_valid), 32'd0);
        chk("flush_stall_ready", 32'(in_ready), 32'd1);
        ex_ready = 1'b1;

        // Decode edges
        set_instr(7'h17, 3'd0, 1'b0, 5'd1, 5'd2, 5'd4, 32'd1, 32'd1, 32'h2000, 32'h100);
        step();
        idle(); #1;
        chk("auipc_a", alu_a, 32'h100);
        chk("auipc_b", alu_b, 32'h2000);
        chk("auipc_op", 32'(alu_op), 32'h2);
        set_instr(7'h63, 3'd6, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 32'd0, 32'd0);
        step();
        idle(); #1;
        chk("bltu_op", 32'(alu_op), 32'hA);
        chk("bltu_wen", 32'(ex_wen), 32'd0);
        set_instr(7'h73, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 32'd0, 32'd0);
        step();
        idle(); #1;
        chk("illegal_flag", 32'(ex_illegal), 32'd1);
        chk("illegal_wen", 32'(ex_wen), 32'd0);
        step();

        // Randomized traffic with a mid-run asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                rst_n = 1'b0;
                #1;
                chk("midrst_valid", 32'(ex_valid), 32'd0);
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            set_instr(($urandom_range(9) == 0) ? 7'($urandom) : opcs[$urandom_range(6)],
                      3'($urandom), 1'($urandom),
                      5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                      $urandom, $urandom, $urandom, $urandom);
            in_valid = ($urandom_range(9) < 7);
            ex_ready = ($urandom_range(9) < 6);
            flush    = ($urandom_range(19) == 0);
            exm_wen  = 1'($urandom); exm_rd = 5'($urandom_range(7)); exm_data = $urandom;
            mwb_wen  = 1'($urandom); mwb_rd = 5'($urandom_range(7)); mwb_data = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the execute-stage ALU.
- Accepts a decoded RV32I instruction and register-file operands from decode, and translates opcode/funct fields into the ALU's 4-bit operation code.
- Resolves EX/MEM and MEM/WB forwarding, selects register or immediate/PC operands, and presents a, b, alu_op to the ALU under a valid/ready handshake with stall and flush.

Parameters:
XLEN, 32, datapath width (ALU width fixed at 32; only 32 is supported)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill the held instruction and any same-cycle capture
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept this cycle
in_pc  in  32  instruction PC
in_opcode  in  7  instr[6:0]
in_funct3  in  3  instr[14:12]
in_funct7b5  in  1  instr[30]
in_rs1_addr  in  5  source 1 index
in_rs2_addr  in  5  source 2 index
in_rd_addr  in  5  destination index
in_rs1_data  in  32  register-file read 1
in_rs2_data  in  32  register-file read 2
in_imm  in  32  sign-extended immediate from decode
exm_wen  in  1  EX/MEM instruction writes rd
exm_rd  in  5  EX/MEM destination
exm_data  in  32  EX/MEM result
mwb_wen  in  1  MEM/WB instruction writes rd
mwb_rd  in  5  MEM/WB destination
mwb_data  in  32  MEM/WB result
ex_valid  out  1  held instruction valid
ex_ready  in  1  EX/MEM accepts this cycle
alu_a  out  32  ALU operand a
alu_b  out  32  ALU operand b
alu_op  out  4  ALU operation code
ex_rs2_val  out  32  forwarded rs2, for store data and branch compare
ex_rd_addr  out  5  registered rd
ex_wen  out  1  instruction writes rd (0 if rd==0)
ex_illegal  out  1  unsupported opcode

Behaviour:
- Reset (rst_n low, async): every register clears to 0, so ex_valid=0, alu_op=4'b0000, ex_wen=0, ex_illegal=0 and all data outputs 0. A reset mid-handshake drops the held instruction.
- in_ready = !ex_valid || ex_ready (combinational).
- Capture occurs when in_valid && in_ready && !flush. Latency is 1 cycle: captured fields appear on outputs at the next edge, and ex_valid goes to 1.
- If ex_valid && ex_ready and no capture occurs, ex_valid goes to 0 next cycle.
- Flush forces ex_valid=0 next cycle, overriding both capture and hold.
- Decode is performed at capture and the result is registered (alu_op, operand selects, wen, illegal).
- alu_op encoding: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, XOR 0100, SLL 0101, SRL 1000, SRA 1001, SLTU 1010.
- OP (0110011) funct3 mapping: 000 gives SUB if funct7b5 else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 gives SRA if funct7b5 else SRL; 110 OR; 111 AND. Operands: a=rs1, b=rs2.
- OP-IMM (0010011): same mapping, except funct3=000 is always ADD. Operands: a=rs1, b=imm.
- LUI (0110111): ADD, a=0, b=imm.
- AUIPC (0010111): ADD, a=pc, b=imm.
- LOAD (0000011) and STORE (0100011): ADD, a=rs1, b=imm. STORE has wen=0.
- BRANCH (1100011): funct3 000/001 gives SUB; 100/101 gives SLT; 110/111 gives SLTU. Operands: a=rs1, b=rs2, wen=0.
- Any other opcode: ex_illegal=1, alu_op=ADD, wen=0.
- ex_wen = decoded wen && rd!=0.
- Forwarding is combinational on the output side, using the registered rs1/rs2 addresses, with a per-source match:
  - If exm_wen && exm_rd==rs && rs!=0, use exm_data.
  - Else if mwb_wen && mwb_rd==rs && rs!=0, use mwb_data.
  - Else use the stored value.
  - EX/MEM has priority when both match. Index 0 never forwards.
- Hold refresh: while ex_valid && !ex_ready, any forward hit is written back into the stored rs value every cycle. The operand therefore survives after the producer leaves the pipeline.
- alu_a, alu_b and ex_rs2_val use the forwarded values. Immediate and PC selections bypass forwarding.
- Outputs are don't-care when ex_valid=0, but registers keep their last values (no clearing on drain).

Test Plan:
- Reset then idle: rst_n=0 -> ex_valid=0, alu_op=0000, in_ready=1. Release, no in_valid -> outputs stay 0.
- R-type SUB (opcode 0110011, f3=000, f7b5=1, rs1_data=10, rs2_data=3, rd=5), ex_ready=1 -> next cycle ex_valid=1, alu_op=0110, a=10, b=3, ex_wen=1. OP-IMM with f7b5=1, f3=000 -> alu_op=0010.
- Forward priority: held instr rs1=7 with exm_wen=1/exm_rd=7/exm_data=0xAAAA and mwb_wen=1/mwb_rd=7/mwb_data=0xBBBB -> alu_a=0xAAAA. With rs1=0 and exm_rd=0 -> alu_a=stored 0.
- Stall refresh: ex_ready=0, mwb forwards rs2=0x55 for one cycle then mwb_wen=0 -> alu_b stays 0x55. in_ready=0 and a new in_valid is not captured until ex_ready=1.
- Flush: in_valid=1, ex_ready=1, flush=1 in the same cycle -> ex_valid=0 next cycle. Flush while stalled -> ex_valid=0, in_ready=1.
- Decode edges: AUIPC pc=0x100 imm=0x2000 -> a=0x100, b=0x2000, alu_op=0010. BLTU -> alu_op=1010, ex_wen=0. Opcode 1110011 -> ex_illegal=1, ex_wen=0.
